// File: rtl/phase_timer_bank.sv
// Phase timer bank: times the one-hot selected traffic-light phase in seconds.
// Define PHASE_TIMER_PAUSE_EN to add a pause input that freezes a running phase.
module phase_timer_bank #(
    parameter int TICK_DIV = 50000000,
    parameter int T1_SEC   = 10,
    parameter int T2_SEC   = 3,
    parameter int T3_SEC   = 5,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
`ifdef PHASE_TIMER_PAUSE_EN
    input  logic             pause,
`endif
    input  logic [2:0]       enable_counters,
    output logic             trigger_next_event,
    output logic [CNT_W-1:0] remaining,
    output logic             enable_error
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    // A zero-second phase still takes one tick so the FSM always advances.
    localparam logic [CNT_W-1:0] D1 = (T1_SEC == 0) ? CNT_W'(1) : CNT_W'(T1_SEC);
    localparam logic [CNT_W-1:0] D2 = (T2_SEC == 0) ? CNT_W'(1) : CNT_W'(T2_SEC);
    localparam logic [CNT_W-1:0] D3 = (T3_SEC == 0) ? CNT_W'(1) : CNT_W'(T3_SEC);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        FIRE,
        SETTLE
    } state_t;

    state_t           state;
    logic [PW-1:0]    prescaler;
    logic [2:0]       cap;
    logic             legal;
    logic             illegal;
    logic             hold;
    logic             tick;
    logic [CNT_W-1:0] dur;

`ifdef PHASE_TIMER_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    assign legal   = $onehot(enable_counters);
    assign illegal = (|enable_counters) && !legal;
    assign tick    = (prescaler == PRE_MAX);

    always_comb begin
        dur = CNT_W'(1);
        case (enable_counters)
            3'b001:  dur = D1;
            3'b010:  dur = D2;
            3'b100:  dur = D3;
            default: dur = CNT_W'(1);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            trigger_next_event <= 1'b0;
            remaining          <= '0;
            enable_error       <= 1'b0;
            prescaler          <= '0;
            cap                <= 3'b000;
        end else begin
            trigger_next_event <= 1'b0;
            unique case (state)
                IDLE: begin
                    remaining <= '0;
                    if (legal) begin
                        state <= LOAD;
                    end else if (illegal) begin
                        enable_error <= 1'b1;
                    end
                end
                LOAD: begin
                    cap       <= enable_counters;
                    remaining <= dur;
                    prescaler <= '0;
                    state     <= RUN;
                end
                RUN: begin
                    // Enable supervision wins over a coincident tick.
                    if (enable_counters == 3'b000) begin
                        remaining <= '0;
                        state     <= IDLE;
                    end else if (illegal) begin
                        enable_error <= 1'b1;
                        remaining    <= '0;
                        state        <= IDLE;
                    end else if (enable_counters != cap) begin
                        state <= LOAD;
                    end else if (!hold) begin
                        if (tick) begin
                            prescaler <= '0;
                            remaining <= remaining - 1'b1;
                            if (remaining == CNT_W'(1)) begin
                                trigger_next_event <= 1'b1;
                                state              <= FIRE;
                            end
                        end else begin
                            prescaler <= prescaler + 1'b1;
                        end
                    end
                end
                FIRE: begin
                    state <= SETTLE;
                end
                SETTLE: begin
                    if (legal) begin
                        state <= LOAD;
                    end else begin
                        state <= IDLE;
                        if (illegal) begin
                            enable_error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phase_timer_bank.sv
// Randomized and directed bench for phase_timer_bank.
// Define PHASE_TIMER_PAUSE_EN to also exercise the pause input.
module tb_phase_timer_bank;

    localparam int DIV = 4;
    localparam int T1  = 3;
    localparam int T2  = 2;
    localparam int T3  = 1;
    localparam int W   = 8;

`ifdef PHASE_TIMER_PAUSE_EN
    localparam bit PAUSE_ON = 1'b1;
`else
    localparam bit PAUSE_ON = 1'b0;
`endif

    localparam int P_IDLE   = 0;
    localparam int P_LOAD   = 1;
    localparam int P_RUN    = 2;
    localparam int P_FIRE   = 3;
    localparam int P_SETTLE = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         pause = 1'b0;
    logic [2:0]   en = 3'b000;
    logic         trigger_next_event;
    logic [W-1:0] remaining;
    logic         enable_error;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: phase kind plus start timestamp; remaining time is
    // derived arithmetically from elapsed cycles.
    int         m_ph;
    int         m_load;
    int         m_dur;
    int         m_paused;
    logic [2:0] m_cap;
    logic       m_trig;
    logic       m_err;
    logic [W-1:0] m_rem;

    always #5 clk = ~clk;

    phase_timer_bank #(
        .TICK_DIV(DIV),
        .T1_SEC(T1),
        .T2_SEC(T2),
        .T3_SEC(T3),
        .CNT_W(W)
    ) dut (
        .clk(clk),
        .reset(reset),
`ifdef PHASE_TIMER_PAUSE_EN
        .pause(pause),
`endif
        .enable_counters(en),
        .trigger_next_event(trigger_next_event),
        .remaining(remaining),
        .enable_error(enable_error)
    );

    function automatic bit is_one_hot(input logic [2:0] e);
        return (e == 3'b001) || (e == 3'b010) || (e == 3'b100);
    endfunction

    function automatic int dur_of(input logic [2:0] e);
        int d;
        d = (e == 3'b001) ? T1 : (e == 3'b010) ? T2 : (e == 3'b100) ? T3 : 1;
        return (d == 0) ? 1 : d;
    endfunction

    task automatic m_reset();
        m_ph   = P_IDLE;
        m_rem  = '0;
        m_trig = 1'b0;
        m_err  = 1'b0;
        m_cap  = 3'b000;
    endtask

    // Drive one cycle of stimulus, advance the model, land on the next negedge.
    task automatic step(input logic [2:0] e, input logic pz);
        bit hot;
        bit bad_e;
        bit hz;
        en    = e;
        pause = pz;
        hot   = is_one_hot(e);
        bad_e = (e != 3'b000) && !hot;
        hz    = pause && PAUSE_ON;
        case (m_ph)
            P_IDLE: begin
                if (hot) m_ph = P_LOAD;
                else if (bad_e) m_err = 1'b1;
            end
            P_LOAD: begin
                m_cap    = e;
                m_dur    = dur_of(e);
                m_load   = cyc;
                m_paused = 0;
                m_ph     = P_RUN;
            end
            P_RUN: begin
                if (e == 3'b000) m_ph = P_IDLE;
                else if (bad_e) begin
                    m_err = 1'b1;
                    m_ph  = P_IDLE;
                end else if (e != m_cap) m_ph = P_LOAD;
                else if (hz) m_paused++;
                else if (cyc - m_load - m_paused == m_dur * DIV) m_ph = P_FIRE;
            end
            P_FIRE: m_ph = P_SETTLE;
            default: begin
                if (hot) m_ph = P_LOAD;
                else begin
                    m_ph = P_IDLE;
                    if (bad_e) m_err = 1'b1;
                end
            end
        endcase
        @(negedge clk);
        cyc++;
        m_trig = (m_ph == P_FIRE);
        if (m_ph == P_RUN)
            m_rem = W'(m_dur - (cyc - m_load - 1 - m_paused) / DIV);
        else if (m_ph != P_LOAD)
            m_rem = '0;
    endtask

    task automatic assert_reset();
        reset = 1'b1;
        #1;
        m_reset();
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        en    = 3'b000;
        pause = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        m_reset();
        total++;
        if (trigger_next_event !== 1'b0) begin
            bad++;
            $display("FAIL reset_trig got=%b want=0", trigger_next_event);
        end
        total++;
        if (remaining !== '0) begin
            bad++;
            $display("FAIL reset_rem got=%0d want=0", remaining);
        end
        total++;
        if (enable_error !== 1'b0) begin
            bad++;
            $display("FAIL reset_err got=%b want=0", enable_error);
        end
        release_reset();
    endtask

    task automatic test_basic();
        logic [W-1:0] r[0:20];
        logic         tg[0:20];
        int idx[4] = '{1, 5, 9, 13};
        int exr[4] = '{3, 2, 1, 0};
        step(3'b001, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            step((i <= 13) ? 3'b001 : 3'b000, 1'b0);
            r[i]  = remaining;
            tg[i] = trigger_next_event;
            total++;
            if ({trigger_next_event, remaining, enable_error} !== {m_trig, m_rem, m_err}) begin
                bad++;
                $display("FAIL basic_model cyc=%0d got %b/%0d/%b want %b/%0d/%b", cyc,
                         trigger_next_event, remaining, enable_error, m_trig, m_rem, m_err);
            end
        end
        for (int j = 0; j < 4; j++) begin
            total++;
            if (r[idx[j]] !== W'(exr[j])) begin
                bad++;
                $display("FAIL basic_rem k+%0d got=%0d want=%0d", idx[j], r[idx[j]], exr[j]);
            end
        end
        total++;
        if ({tg[12], tg[13], tg[14]} !== 3'b010) begin
            bad++;
            $display("FAIL basic_trig k+12..14 got=%b want=010", {tg[12], tg[13], tg[14]});
        end
        total++;
        if (enable_error !== 1'b0) begin
            bad++;
            $display("FAIL basic_err got=%b want=0", enable_error);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] r[0:40];
        int t1 = -1;
        int t2 = -1;
        step(3'b010, 1'b0);
        for (int i = 1; i <= 30; i++) begin
            step(3'b010, 1'b0);
            r[i] = remaining;
            if (trigger_next_event && t1 < 0) t1 = i;
            else if (trigger_next_event && t2 < 0) t2 = i;
            total++;
            if ({trigger_next_event, remaining, enable_error} !== {m_trig, m_rem, m_err}) begin
                bad++;
                $display("FAIL b2b_model cyc=%0d got %b/%0d/%b want %b/%0d/%b", cyc,
                         trigger_next_event, remaining, enable_error, m_trig, m_rem, m_err);
            end
        end
        total++;
        if (t1 != 2 * DIV + 1) begin
            bad++;
            $display("FAIL b2b_first got=k+%0d want=k+%0d", t1, 2 * DIV + 1);
        end
        total++;
        if (t2 - t1 != 2 * DIV + 3) begin
            bad++;
            $display("FAIL b2b_period got=%0d want=%0d", t2 - t1, 2 * DIV + 3);
        end
        total++;
        if (t1 > 0 && r[t1 + 3] !== W'(T2)) begin
            bad++;
            $display("FAIL b2b_reload got=%0d want=%0d", r[t1 + 3], T2);
        end
        for (int i = 0; i < 3; i++) begin
            step(3'b000, 1'b0);
            total++;
            if ({trigger_next_event, remaining} !== {m_trig, m_rem}) begin
                bad++;
                $display("FAIL b2b_idle cyc=%0d got %b/%0d want %b/%0d", cyc,
                         trigger_next_event, remaining, m_trig, m_rem);
            end
        end
    endtask

    task automatic test_abort();
        logic [W-1:0] r[0:20];
        logic         tg[0:20];
        step(3'b001, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            step((i <= 6) ? 3'b001 : (i <= 14) ? 3'b100 : 3'b000, 1'b0);
            r[i]  = remaining;
            tg[i] = trigger_next_event;
            total++;
            if ({trigger_next_event, remaining, enable_error} !== {m_trig, m_rem, m_err}) begin
                bad++;
                $display("FAIL abort_model cyc=%0d got %b/%0d/%b want %b/%0d/%b", cyc,
                         trigger_next_event, remaining, enable_error, m_trig, m_rem, m_err);
            end
        end
        total++;
        if (r[6] !== W'(2)) begin
            bad++;
            $display("FAIL abort_pre_rem got=%0d want=2", r[6]);
        end
        total++;
        if (r[8] !== W'(T3)) begin
            bad++;
            $display("FAIL abort_reload got=%0d want=%0d", r[8], T3);
        end
        for (int i = 1; i <= 11; i++) begin
            total++;
            if (tg[i] !== 1'b0) begin
                bad++;
                $display("FAIL abort_no_pulse k+%0d got=1 want=0", i);
            end
        end
        total++;
        if (tg[12] !== 1'b1) begin
            bad++;
            $display("FAIL abort_pulse k+12 got=%b want=1", tg[12]);
        end
    endtask

    task automatic test_illegal();
        logic [2:0] seq[0:25];
        int         tpulse = -1;
        for (int i = 0; i < 26; i++) seq[i] = 3'b001;
        seq[0] = 3'b011;
        seq[1] = 3'b011;
        seq[17] = 3'b000;
        seq[18] = 3'b000;
        seq[19] = 3'b000;
        seq[24] = 3'b110;
        seq[25] = 3'b000;
        for (int i = 0; i < 26; i++) begin
            step(seq[i], 1'b0);
            if (trigger_next_event && tpulse < 0) tpulse = i;
            total++;
            if ({trigger_next_event, remaining, enable_error} !== {m_trig, m_rem, m_err}) begin
                bad++;
                $display("FAIL illegal_model cyc=%0d got %b/%0d/%b want %b/%0d/%b", cyc,
                         trigger_next_event, remaining, enable_error, m_trig, m_rem, m_err);
            end
            if (i <= 1 || i == 25) begin
                total++;
                if ({trigger_next_event, remaining, enable_error} !== {1'b0, W'(0), 1'b1}) begin
                    bad++;
                    $display("FAIL illegal_idle step=%0d got %b/%0d/%b want 0/0/1", i,
                             trigger_next_event, remaining, enable_error);
                end
            end
        end
        total++;
        if (tpulse != 2 + T1 * DIV + 1) begin
            bad++;
            $display("FAIL illegal_resume got=%0d want=%0d", tpulse, 2 + T1 * DIV + 1);
        end
    endtask

    task automatic test_reset_async();
        int t = -1;
        assert_reset();
        release_reset();
        step(3'b001, 1'b0);
        repeat (6) step(3'b001, 1'b0);
        total++;
        if (remaining !== W'(2)) begin
            bad++;
            $display("FAIL rst_pre_rem got=%0d want=2", remaining);
        end
        assert_reset();
        total++;
        if ({trigger_next_event, remaining, enable_error} !== {1'b0, W'(0), 1'b0}) begin
            bad++;
            $display("FAIL rst_run got %b/%0d/%b want 0/0/0",
                     trigger_next_event, remaining, enable_error);
        end
        release_reset();
        step(3'b010, 1'b0);
        for (int i = 1; i <= 12 && t < 0; i++) begin
            step(3'b010, 1'b0);
            if (trigger_next_event) t = i;
            total++;
            if ({trigger_next_event, remaining} !== {m_trig, m_rem}) begin
                bad++;
                $display("FAIL rst_fresh cyc=%0d got %b/%0d want %b/%0d", cyc,
                         trigger_next_event, remaining, m_trig, m_rem);
            end
        end
        total++;
        if (t != T2 * DIV + 1) begin
            bad++;
            $display("FAIL rst_fresh_lat got=%0d want=%0d", t, T2 * DIV + 1);
        end
        assert_reset();
        total++;
        if (trigger_next_event !== 1'b0) begin
            bad++;
            $display("FAIL rst_fire got=%b want=0", trigger_next_event);
        end
        release_reset();
    endtask

`ifdef PHASE_TIMER_PAUSE_EN
    task automatic test_pause();
        logic [W-1:0] r[0:30];
        logic         tg[0:30];
        step(3'b001, 1'b0);
        for (int i = 1; i <= 26; i++) begin
            step((i <= 23) ? 3'b001 : 3'b000, (i >= 6 && i <= 15));
            r[i]  = remaining;
            tg[i] = trigger_next_event;
            total++;
            if ({trigger_next_event, remaining} !== {m_trig, m_rem}) begin
                bad++;
                $display("FAIL pause_model cyc=%0d got %b/%0d want %b/%0d", cyc,
                         trigger_next_event, remaining, m_trig, m_rem);
            end
        end
        total++;
        if (r[10] !== W'(2) || r[15] !== W'(2)) begin
            bad++;
            $display("FAIL pause_hold got=%0d,%0d want=2,2", r[10], r[15]);
        end
        total++;
        if ({tg[13], tg[22], tg[23]} !== 3'b001) begin
            bad++;
            $display("FAIL pause_delay got=%b want=001", {tg[13], tg[22], tg[23]});
        end
    endtask
`endif

    task automatic test_random();
        logic [2:0] e = 3'b000;
        logic [2:0] ill[4] = '{3'b011, 3'b101, 3'b110, 3'b111};
        logic       pz;
        int         roll;
        for (int i = 0; i < 800; i++) begin
            roll = $urandom_range(0, 99);
            if (m_ph != P_LOAD) begin
                if (roll >= 97) e = ill[$urandom_range(0, 3)];
                else if (roll >= 93) e = 3'b000;
                else if (roll >= 85) e = 3'(1 << $urandom_range(0, 2));
            end
            pz = ($urandom_range(0, 3) == 0);
            step(e, pz);
            total++;
            if ({trigger_next_event, remaining, enable_error} !== {m_trig, m_rem, m_err}) begin
                bad++;
                $display("FAIL random cyc=%0d en=%b got %b/%0d/%b want %b/%0d/%b", cyc, e,
                         trigger_next_event, remaining, enable_error, m_trig, m_rem, m_err);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        m_reset();
        test_reset();
        test_basic();
        test_back_to_back();
        test_abort();
        test_illegal();
        test_reset_async();
`ifdef PHASE_TIMER_PAUSE_EN
        test_pause();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
